// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register file with busy scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default register width and index width
//   reg_addr_t / reg_data_t : register index and data types at default widths
//   ZERO_ADDR               : index of the hard-wired zero register
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
// Bundles the read, write, issue and flush signals of the register file.
//   master : datapath / control side (drives addresses, write and issue)
//   slave  : register file side (returns read data, busy flags and stall)
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     issue_stall;
  logic                     flush;

  modport master (
    output rd_addr, we, wa, wd, issue_valid, issue_addr, flush,
    input  rd_data, rd_busy, issue_stall
  );

  modport slave (
    input  rd_addr, we, wa, wd, issue_valid, issue_addr, flush,
    output rd_data, rd_busy, issue_stall
  );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One combinational read port: selects the addressed register, forwards a
// same-cycle write, and masks the busy flag when that write resolves the hazard.
//   rd_addr   : register index read by this port
//   reg_array : current register contents
//   busy      : current per-register busy flags
//   we/wa/wd  : write port, used for write-to-read bypass
//   rd_data   : read result
//   rd_busy   : source register still has a pending writer
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      reg_array [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]   busy,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  input  logic [DATA_W-1:0]      wd,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_busy
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_ADDR);

  logic zero_hit_s;
  logic bypass_hit_s;

  // Classify the read address: hard-wired zero, or hit by the write in flight.
  always_comb begin
    zero_hit_s   = (ZERO_REG == 1) && (rd_addr == ZERO_IDX);
    bypass_hit_s = we && (wa == rd_addr) && !zero_hit_s;
  end

  // Read mux; zero register beats bypass, bypass beats stored state.
  always_comb begin
    rd_data = reg_array[rd_addr];
    rd_busy = busy[rd_addr];
    if (zero_hit_s) begin
      rd_data = {DATA_W{1'b0}};
      rd_busy = 1'b0;
    end else if (bypass_hit_s) begin
      // The writeback landing this cycle both supplies the value and
      // retires the pending write, so the consumer need not stall.
      rd_data = wd;
      rd_busy = 1'b0;
    end else begin
      rd_data = reg_array[rd_addr];
      rd_busy = busy[rd_addr];
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Register file with NUM_RD combinational read ports, one synchronous write
// port with write-to-read bypass, and a per-register busy scoreboard used by
// the control FSM to stall on RAW hazards against multi-cycle writers.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears data and busy bits)
//   bus   : slave side of regfile_scoreboard_if
//           rd_addr/rd_data/rd_busy  packed read ports
//           we/wa/wd                 write port
//           issue_valid/issue_addr   destination reservation request
//           issue_stall              reservation refused this cycle
//           flush                    clear every busy bit at the edge
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_scoreboard_if.slave   bus
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0]        regs_r [DEPTH];
  logic [DEPTH-1:0]         busy_r;
  logic [DEPTH-1:0]         busy_next_s;

  logic                     wa_zero_s;
  logic                     ia_zero_s;
  logic                     write_en_s;
  logic                     byp_we_s;
  logic                     issue_stall_s;
  logic                     issue_accept_s;

  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]        rd_busy_s;

  // Decode write and issue requests against the zero register and scoreboard.
  always_comb begin
    wa_zero_s  = (ZERO_REG == 1) && (bus.wa == ZERO_IDX);
    ia_zero_s  = (ZERO_REG == 1) && (bus.issue_addr == ZERO_IDX);
    write_en_s = bus.we && !wa_zero_s;
    // Bypass is suppressed while in reset so reads reflect the cleared state.
    byp_we_s   = bus.we && rst_n;
    // A writeback to the same register in this cycle resolves the hazard.
    issue_stall_s  = bus.issue_valid && busy_r[bus.issue_addr]
                     && !(bus.we && (bus.wa == bus.issue_addr))
                     && !ia_zero_s;
    issue_accept_s = bus.issue_valid && !issue_stall_s && !bus.flush && !ia_zero_s;
  end

  // Next busy vector: flush clears all, a new reservation wins over a writeback clear.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush) begin
        busy_next_s[i] = 1'b0;
      end else if (issue_accept_s && (bus.issue_addr == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b1;
      end else if (write_en_s && (bus.wa == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
  end

  // Register storage: cleared by reset, updated by the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (write_en_s) begin
      regs_r[bus.wa] <= bus.wd;
    end
  end

  // Busy scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // One read port instance per requested port.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .rd_addr   (bus.rd_addr[g*ADDR_W +: ADDR_W]),
      .reg_array (regs_r),
      .busy      (busy_r),
      .we        (byp_we_s),
      .wa        (bus.wa),
      .wd        (bus.wd),
      .rd_data   (rd_data_s[g*DATA_W +: DATA_W]),
      .rd_busy   (rd_busy_s[g])
    );
  end

  assign bus.rd_data     = rd_data_s;
  assign bus.rd_busy     = rd_busy_s;
  assign bus.issue_stall = issue_stall_s;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// Self-checking bench: a default 32-bit/2-port instance driven from a vector
// table plus a reset sequence, and a 16-bit/4-port instance driven with
// random traffic against a reference model. Expected values go through a
// queue: pushed when stimulus is applied, popped when outputs are sampled.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4)) bus_b ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic        we;
    reg_addr_t   wa;
    reg_data_t   wd;
    reg_addr_t   r0;
    reg_addr_t   r1;
    logic        iv;
    reg_addr_t   ia;
    logic        fl;
    reg_data_t   d0;
    reg_data_t   d1;
    logic        b0;
    logic        b1;
    logic        st;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  busy;
    logic        stall;
  } exp_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];
  exp_t sb_q [$];

  int checks = 0;
  int errors = 0;

  // reference model for the 16-bit instance
  logic [15:0] m_regs [32];
  logic [31:0] m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [63:0] act_d,
                          input logic [3:0] act_b, input logic act_s);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_data"},  act_d, e.data);
      chk({name, "_busy"},  {60'd0, act_b}, {60'd0, e.busy});
      chk({name, "_stall"}, {63'd0, act_s}, {63'd0, e.stall});
    end
  endtask

  task automatic idle_a();
    bus_a.we = 1'b0; bus_a.wa = 5'd0; bus_a.wd = 32'd0;
    bus_a.rd_addr = 10'd0; bus_a.issue_valid = 1'b0;
    bus_a.issue_addr = 5'd0; bus_a.flush = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.we = 1'b0; bus_b.wa = 5'd0; bus_b.wd = 16'd0;
    bus_b.rd_addr = 20'd0; bus_b.issue_valid = 1'b0;
    bus_b.issue_addr = 5'd0; bus_b.flush = 1'b0;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.we = v.we; bus_a.wa = v.wa; bus_a.wd = v.wd;
    bus_a.rd_addr = {v.r1, v.r0};
    bus_a.issue_valid = v.iv; bus_a.issue_addr = v.ia; bus_a.flush = v.fl;
  endtask

  task automatic sample_a(input string name);
    sb_check(name, {32'd0, bus_a.rd_data}, {2'b00, bus_a.rd_busy}, bus_a.issue_stall);
  endtask

  initial begin
    exp_t e;
    logic        r_we, r_iv, r_fl, r_st;
    logic [4:0]  r_wa, r_ia, a;
    logic [15:0] r_wd;
    logic [19:0] r_rd;

    // we wa wd r0 r1 iv ia fl | d0 d1 b0 b1 st
    vecs[0]  = '{1'b1, 5'd0,  32'h0000_1234, 5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd5,  32'hA5A5_0001, 5'd5,  5'd6,  1'b0, 5'd0,  1'b0, 32'hA5A5_0001, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd6,  1'b0, 5'd0,  1'b0, 32'hA5A5_0001, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  1'b1, 5'd7,  1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  1'b1, 5'd7,  1'b0, 32'h0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 5'd7,  32'd9,         5'd7,  5'd7,  1'b1, 5'd7,  1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         5'd8,  5'd7,  1'b1, 5'd8,  1'b0, 32'h0, 32'd9, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 5'd8,  32'd42,        5'd8,  5'd8,  1'b1, 5'd8,  1'b0, 32'd42, 32'd42, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         5'd8,  5'd8,  1'b0, 5'd0,  1'b0, 32'd42, 32'd42, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  1'b1, 5'd1,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  1'b1, 5'd2,  1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         5'd2,  5'd3,  1'b1, 5'd3,  1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 5'd11, 32'd77,        5'd3,  5'd4,  1'b1, 5'd4,  1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  1'b0, 5'd0,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd4,  1'b0, 5'd0,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd8,  1'b0, 5'd0,  1'b0, 32'd9, 32'd42, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 5'd0,  32'h0,         5'd11, 5'd11, 1'b0, 5'd0,  1'b0, 32'd77, 32'd77, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 5'd0,  32'h0,         5'd12, 5'd13, 1'b1, 5'd12, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 5'd13, 32'd5,         5'd12, 5'd13, 1'b1, 5'd12, 1'b0, 32'h0, 32'd5, 1'b1, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 5'd0,  32'h0,         5'd12, 5'd13, 1'b0, 5'd0,  1'b0, 32'h0, 32'd5, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    idle_a();
    idle_b();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset state
    @(posedge clk); #1;
    bus_a.rd_addr = {5'd10, 5'd3};
    @(negedge clk);
    chk("reset_data", {32'd0, bus_a.rd_data}, 64'd0);
    chk("reset_busy", {62'd0, bus_a.rd_busy}, 64'd0);
    chk("reset_stall", {63'd0, bus_a.issue_stall}, 64'd0);

    // Commit r3 and reserve r10
    @(posedge clk); #1;
    bus_a.we = 1'b1; bus_a.wa = 5'd3; bus_a.wd = 32'h1111_1111;
    bus_a.issue_valid = 1'b1; bus_a.issue_addr = 5'd10;
    @(negedge clk);
    chk("pre_bypass", {32'd0, bus_a.rd_data[31:0]}, 64'h1111_1111);

    // Reset asserted in the middle of a write to r3
    @(posedge clk); #1;
    bus_a.wd = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("pre_busy_r10", {63'd0, bus_a.rd_busy[1]}, 64'd1);
    chk("pre_stall_r10", {63'd0, bus_a.issue_stall}, 64'd1);
    chk("pre_data_r3", {32'd0, bus_a.rd_data[31:0]}, 64'hDEAD_BEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("inrst_data", {32'd0, bus_a.rd_data}, 64'd0);
    chk("inrst_busy", {62'd0, bus_a.rd_busy}, 64'd0);
    chk("inrst_stall", {63'd0, bus_a.issue_stall}, 64'd0);
    idle_a();
    bus_a.rd_addr = {5'd10, 5'd3};
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_data", {32'd0, bus_a.rd_data}, 64'd0);
    chk("postrst_busy", {62'd0, bus_a.rd_busy}, 64'd0);

    // Table-driven sequence on the 2-port instance
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      drive_a(vecs[i]);
      e.data  = {vecs[i].d1, vecs[i].d0};
      e.busy  = {2'b00, vecs[i].b1, vecs[i].b0};
      e.stall = vecs[i].st;
      sb_q.push_back(e);
      @(negedge clk);
      sample_a($sformatf("row%0d", i));
    end
    @(posedge clk); #1;
    idle_a();

    // 4-port instance: all ports read r9 in the write cycle and after it
    for (int k = 0; k < 32; k++) m_regs[k] = 16'd0;
    m_busy = 32'd0;
    for (int c = 0; c < 2; c++) begin
      if (c != 0) @(posedge clk);
      #1;
      bus_b.we = (c == 0); bus_b.wa = 5'd9; bus_b.wd = 16'hBEEF;
      bus_b.rd_addr = {5'd9, 5'd9, 5'd9, 5'd9};
      e.data = {4{16'hBEEF}};
      e.busy = 4'b0000;
      e.stall = 1'b0;
      sb_q.push_back(e);
      @(negedge clk);
      sb_check($sformatf("r9_all_ports_c%0d", c), bus_b.rd_data, bus_b.rd_busy, bus_b.issue_stall);
    end
    m_regs[9] = 16'hBEEF;

    // Random traffic against the reference model
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      r_we = 1'($urandom_range(0, 1));
      r_wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r_wd = 16'($urandom);
      for (int p = 0; p < 4; p++) begin
        r_rd[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      end
      r_iv = 1'($urandom_range(0, 1));
      r_ia = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r_fl = ($urandom_range(0, 31) == 0);
      bus_b.we = r_we; bus_b.wa = r_wa; bus_b.wd = r_wd; bus_b.rd_addr = r_rd;
      bus_b.issue_valid = r_iv; bus_b.issue_addr = r_ia; bus_b.flush = r_fl;

      for (int p = 0; p < 4; p++) begin
        a = r_rd[p*5 +: 5];
        if (a == 5'd0) begin
          e.data[p*16 +: 16] = 16'd0;
          e.busy[p] = 1'b0;
        end else if (r_we && (r_wa == a)) begin
          e.data[p*16 +: 16] = r_wd;
          e.busy[p] = 1'b0;
        end else begin
          e.data[p*16 +: 16] = m_regs[a];
          e.busy[p] = m_busy[a];
        end
      end
      r_st = r_iv && (r_ia != 5'd0) && m_busy[r_ia] && !(r_we && (r_wa == r_ia));
      e.stall = r_st;
      sb_q.push_back(e);

      @(negedge clk);
      sb_check($sformatf("rand%0d", n), bus_b.rd_data, bus_b.rd_busy, bus_b.issue_stall);

      // state the DUT commits at the coming edge
      if (r_we && (r_wa != 5'd0)) m_regs[r_wa] = r_wd;
      if (r_fl) begin
        m_busy = 32'd0;
      end else begin
        if (r_we && (r_wa != 5'd0)) m_busy[r_wa] = 1'b0;
        if (r_iv && !r_st && (r_ia != 5'd0)) m_busy[r_ia] = 1'b1;
      end
    end
    @(posedge clk); #1;
    idle_b();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
